instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Upstream neighbour of the control signal generator: the fetch stage that feeds it the 32-bit Instruction word.
- Owns the program counter, its return-address copy (PC_Temp) and the instruction register.
- Reads ROM1 through a ready handshake with variable wait states.
- Applies the PC_Enable/PC_Select/INC_Select/IR_Enable controls produced by the control generator.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value after reset (word-aligned).
- NOP_WORD, 32'h0000_0000, IR value after reset and after a fetch timeout.
- TIMEOUT, 15, max WAIT cycles before a fetch is abandoned; range 1..255.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- IR_Enable  in  1  start a fetch at the current PC into IR.
- PC_Enable  in  1  update PC this cycle.
- PC_Select  in  1  0 = incremented PC, 1 = Jump_Target.
- INC_Select  in  1  0 = increment by 4, 1 = increment by Branch_Offset.
- Branch_Offset  in  32  sign-extended byte offset (from immediate block).
- Jump_Target  in  32  register jump address (RA).
- ROM_Data  in  32  ROM1 read data, valid when ROM_Ready=1.
- ROM_Ready  in  1  ROM1 data-valid strobe.
- ROM_Addr  out  32  ROM1 address, word-aligned.
- ROM1_Read  out  1  ROM1 read request.
- Instruction  out  32  IR contents.
- PC  out  32  current program counter.
- PC_Temp  out  32  PC+4 captured at last PC update (link value).
- Fetch_Busy  out  1  high in WAIT.
- Fetch_Done  out  1  one-cycle pulse when IR loads valid data.
- Fetch_Error  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset, checked first every edge:
  - PC=RESET_VECTOR, PC_Temp=RESET_VECTOR+4, Instruction=NOP_WORD.
  - ROM1_Read=0, ROM_Addr=0, Fetch_Busy/Done/Error=0, pending=0, wait count=0, state=IDLE.
  - Reset in WAIT abandons the fetch; no IR write.
- States: IDLE, WAIT.
- IDLE + IR_Enable: next cycle ROM1_Read=1, ROM_Addr={PC[31:2],2'b00}, Fetch_Busy=1, state=WAIT, wait count=0. ROM_Addr uses the PC value before any same-cycle update.
- WAIT:
  - ROM1_Read and ROM_Addr held stable.
  - ROM_Ready=1: Instruction<=ROM_Data, Fetch_Done=1 for one cycle, ROM1_Read=0, state=IDLE. Minimum latency is 2 edges from IR_Enable to Fetch_Done.
  - ROM_Ready=0: wait count increments.
  - ROM_Ready=0 with count==TIMEOUT-1: Instruction<=NOP_WORD, Fetch_Error=1 for one cycle, state=IDLE.
  - IR_Enable is ignored; no queue.
- PC update (when applied):
  - PC_Temp<=PC+4.
  - PC<=PC_Select ? Jump_Target : PC+(INC_Select ? Branch_Offset : 4).
  - Arithmetic is 32-bit, wraps modulo 2^32; bits [1:0] are forced to 0 on load.
- PC_Enable in IDLE: applied that edge. IR_Enable in the same cycle fetches from the old PC and the PC updates concurrently.
- PC_Enable in WAIT: one-entry pending register captures select bits and operands, applied on the edge that leaves WAIT, so ROM_Addr never changes mid-fetch. A second PC_Enable during the same WAIT overwrites the pending entry (last wins).
- ROM_Ready in IDLE is ignored.

Decomposition:
- Shared package (fetch_pkg):
  - state encoding IDLE/WAIT;
  - constant WORD_INC=4;
  - the RESET_VECTOR and NOP_WORD defaults.
- One natural sub-module: pc_next_calc, the combinational next-PC/PC_Temp adder-mux shared by the immediate and pending paths.

Test Plan:
- Reset, then IR_Enable with ROM_Ready asserted the cycle after ROM1_Read -> ROM_Addr=0x0, Instruction=ROM_Data (0x1234_5678), Fetch_Done one pulse, PC unchanged at 0x0.
- PC=0x10, PC_Enable with PC_Select=0, INC_Select=0 -> PC=0x14, PC_Temp=0x14; then INC_Select=1, Branch_Offset=0xFFFF_FFF8 -> PC=0x0C, PC_Temp=0x18.
- PC_Select=1, Jump_Target=0x0000_0103 -> PC=0x0000_0100 (aligned); PC=0xFFFF_FFFC with +4 -> PC=0x0.
- Fetch at PC=0x20 with 3 wait states, PC_Enable (jump to 0x80) during WAIT -> ROM_Addr stays 0x20 throughout; PC=0x80 on the Fetch_Done edge; PC_Temp=0x24.
- ROM_Ready never asserted, TIMEOUT=15 -> after 15 WAIT cycles Instruction=NOP_WORD, Fetch_Error one pulse, state IDLE, ROM1_Read=0.
- Reset asserted on the 2nd WAIT cycle -> next edge all outputs at reset values, IR=NOP_WORD; a later ROM_Ready in IDLE is ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// word increment and the default reset/NOP values.
package fetch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

    localparam logic [31:0] WORD_INC             = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_WORD     = 32'h0000_0000;

    function automatic logic [31:0] alignWord(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC and link-value calculation, shared by the immediate
// (IDLE) update path and the deferred (pending) update path.
module pc_next_calc
    import fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        pcSelect_i,
    input  logic        incSelect_i,
    input  logic [31:0] branchOffset_i,
    input  logic [31:0] jumpTarget_i,
    output logic [31:0] pcNext_o,
    output logic [31:0] pcTemp_o
);

    logic [31:0] increment;
    logic [31:0] incremented;

    always_comb begin
        increment   = incSelect_i ? branchOffset_i : WORD_INC;
        incremented = pc_i + increment;
        pcNext_o    = alignWord(pcSelect_i ? jumpTarget_i : incremented);
        pcTemp_o    = alignWord(pc_i + WORD_INC);
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns PC, PC_Temp and IR, reads ROM1 through a ready handshake
// with a bounded number of wait states, and defers PC updates during a fetch.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] NOP_WORD     = DEFAULT_NOP_WORD,
    parameter int unsigned TIMEOUT      = 15
)(
    input  logic        Clock,
    input  logic        Reset,
    input  logic        IR_Enable,
    input  logic        PC_Enable,
    input  logic        PC_Select,
    input  logic        INC_Select,
    input  logic [31:0] Branch_Offset,
    input  logic [31:0] Jump_Target,
    input  logic [31:0] ROM_Data,
    input  logic        ROM_Ready,
    output logic [31:0] ROM_Addr,
    output logic        ROM1_Read,
    output logic [31:0] Instruction,
    output logic [31:0] PC,
    output logic [31:0] PC_Temp,
    output logic        Fetch_Busy,
    output logic        Fetch_Done,
    output logic        Fetch_Error
);

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    fetch_state_t state_q;
    logic [31:0]  pc_q, pcTemp_q, ir_q, romAddr_q;
    logic         romRead_q, busy_q, done_q, error_q;
    logic [7:0]   waitCnt_q;

    logic         pending_q, pendPcSel_q, pendIncSel_q;
    logic [31:0]  pendOffset_q, pendJump_q;

    logic         usePending;
    logic         calcPcSel, calcIncSel;
    logic [31:0]  calcOffset, calcJump;
    logic [31:0]  pcNext_d, pcTemp_d;
    logic         leaveWait, timeoutHit, applyOnLeave;

    // A PC_Enable arriving on the very edge that leaves WAIT supersedes the
    // stored entry, so the pending operands feed the adder only when idle-free.
    always_comb begin
        usePending   = (state_q == WAIT) && !PC_Enable;
        calcPcSel    = usePending ? pendPcSel_q  : PC_Select;
        calcIncSel   = usePending ? pendIncSel_q : INC_Select;
        calcOffset   = usePending ? pendOffset_q : Branch_Offset;
        calcJump     = usePending ? pendJump_q   : Jump_Target;
        timeoutHit   = !ROM_Ready && (waitCnt_q == LAST_WAIT);
        leaveWait    = (state_q == WAIT) && (ROM_Ready || timeoutHit);
        applyOnLeave = PC_Enable || pending_q;
    end

    pc_next_calc u_pcNextCalc (
        .pc_i           (pc_q),
        .pcSelect_i     (calcPcSel),
        .incSelect_i    (calcIncSel),
        .branchOffset_i (calcOffset),
        .jumpTarget_i   (calcJump),
        .pcNext_o       (pcNext_d),
        .pcTemp_o       (pcTemp_d)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_VECTOR;
            pcTemp_q     <= RESET_VECTOR + WORD_INC;
            ir_q         <= NOP_WORD;
            romAddr_q    <= '0;
            romRead_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            waitCnt_q    <= '0;
            pending_q    <= 1'b0;
            pendPcSel_q  <= 1'b0;
            pendIncSel_q <= 1'b0;
            pendOffset_q <= '0;
            pendJump_q   <= '0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (IR_Enable) begin
                        romRead_q <= 1'b1;
                        romAddr_q <= alignWord(pc_q);
                        busy_q    <= 1'b1;
                        waitCnt_q <= '0;
                        state_q   <= WAIT;
                    end
                    if (PC_Enable) begin
                        pc_q     <= pcNext_d;
                        pcTemp_q <= pcTemp_d;
                    end
                end
                WAIT: begin
                    if (leaveWait) begin
                        if (ROM_Ready) begin
                            ir_q   <= ROM_Data;
                            done_q <= 1'b1;
                        end else begin
                            ir_q    <= NOP_WORD;
                            error_q <= 1'b1;
                        end
                        if (applyOnLeave) begin
                            pc_q     <= pcNext_d;
                            pcTemp_q <= pcTemp_d;
                        end
                        romRead_q <= 1'b0;
                        busy_q    <= 1'b0;
                        waitCnt_q <= '0;
                        pending_q <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        waitCnt_q <= waitCnt_q + 8'd1;
                        if (PC_Enable) begin
                            pending_q    <= 1'b1;
                            pendPcSel_q  <= PC_Select;
                            pendIncSel_q <= INC_Select;
                            pendOffset_q <= Branch_Offset;
                            pendJump_q   <= Jump_Target;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ROM_Addr    = romAddr_q;
    assign ROM1_Read   = romRead_q;
    assign Instruction = ir_q;
    assign PC          = pc_q;
    assign PC_Temp     = pcTemp_q;
    assign Fetch_Busy  = busy_q;
    assign Fetch_Done  = done_q;
    assign Fetch_Error = error_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for the fetch stage: reset, handshake, PC arithmetic,
// deferred PC update during a fetch, timeout and reset mid-fetch.
module tb_instruction_fetch_unit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        IR_Enable, PC_Enable, PC_Select, INC_Select;
    logic [31:0] Branch_Offset, Jump_Target, ROM_Data;
    logic        ROM_Ready;
    logic [31:0] ROM_Addr, Instruction, PC, PC_Temp;
    logic        ROM1_Read, Fetch_Busy, Fetch_Done, Fetch_Error;

    int checkCount = 0;
    int errorCount = 0;

    instruction_fetch_unit #(
        .RESET_VECTOR (32'h0000_0000),
        .NOP_WORD     (32'h0000_0000),
        .TIMEOUT      (15)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .IR_Enable     (IR_Enable),
        .PC_Enable     (PC_Enable),
        .PC_Select     (PC_Select),
        .INC_Select    (INC_Select),
        .Branch_Offset (Branch_Offset),
        .Jump_Target   (Jump_Target),
        .ROM_Data      (ROM_Data),
        .ROM_Ready     (ROM_Ready),
        .ROM_Addr      (ROM_Addr),
        .ROM1_Read     (ROM1_Read),
        .Instruction   (Instruction),
        .PC            (PC),
        .PC_Temp       (PC_Temp),
        .Fetch_Busy    (Fetch_Busy),
        .Fetch_Done    (Fetch_Done),
        .Fetch_Error   (Fetch_Error)
    );

    always #5 Clock = ~Clock;

    // Compares one observed value against its expectation and logs a miss.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic irEn, input logic pcEn, input logic pcSel,
                                 input logic incSel, input logic [31:0] offset,
                                 input logic [31:0] jump, input logic ready,
                                 input logic [31:0] data);
        IR_Enable     = irEn;
        PC_Enable     = pcEn;
        PC_Select     = pcSel;
        INC_Select    = incSel;
        Branch_Offset = offset;
        Jump_Target   = jump;
        ROM_Ready     = ready;
        ROM_Data      = data;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " PC"}, PC, 32'h0);
        checkOutput({tag, " PC_Temp"}, PC_Temp, 32'h4);
        checkOutput({tag, " IR"}, Instruction, 32'h0);
        checkOutput({tag, " ROM_Addr"}, ROM_Addr, 32'h0);
        checkOutput({tag, " ROM1_Read"}, {31'b0, ROM1_Read}, 32'h0);
        checkOutput({tag, " Busy"}, {31'b0, Fetch_Busy}, 32'h0);
        checkOutput({tag, " Done"}, {31'b0, Fetch_Done}, 32'h0);
        checkOutput({tag, " Error"}, {31'b0, Fetch_Error}, 32'h0);
    endtask

    initial begin
        Reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        tick();
        checkResetValues("reset");
        Reset = 1'b0;

        // Minimum-latency fetch from address 0
        applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        tick();
        checkOutput("f1 read", {31'b0, ROM1_Read}, 32'h1);
        checkOutput("f1 busy", {31'b0, Fetch_Busy}, 32'h1);
        checkOutput("f1 addr", ROM_Addr, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h1234_5678);
        tick();
        checkOutput("f1 ir", Instruction, 32'h1234_5678);
        checkOutput("f1 done", {31'b0, Fetch_Done}, 32'h1);
        checkOutput("f1 read off", {31'b0, ROM1_Read}, 32'h0);
        checkOutput("f1 pc", PC, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        tick();
        checkOutput("f1 done pulse", {31'b0, Fetch_Done}, 32'h0);

        // PC arithmetic in IDLE
        applyStimulus(0, 1, 1, 0, 32'h0, 32'h10, 0, 32'h0);
        tick();
        checkOutput("jmp10 pc", PC, 32'h10);
        checkOutput("jmp10 tmp", PC_Temp, 32'h4);
        applyStimulus(0, 1, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        tick();
        checkOutput("inc4 pc", PC, 32'h14);
        checkOutput("inc4 tmp", PC_Temp, 32'h14);
        applyStimulus(0, 1, 0, 1, 32'hFFFF_FFF8, 32'h0, 0, 32'h0);
        tick();
        checkOutput("br-8 pc", PC, 32'h0C);
        checkOutput("br-8 tmp", PC_Temp, 32'h18);
        applyStimulus(0, 1, 1, 0, 32'h0, 32'h0000_0103, 0, 32'h0);
        tick();
        checkOutput("jmp align pc", PC, 32'h100);
        checkOutput("jmp align tmp", PC_Temp, 32'h10);
        applyStimulus(0, 1, 1, 0, 32'h0, 32'hFFFF_FFFC, 0, 32'h0);
        tick();
        checkOutput("jmp top pc", PC, 32'hFFFF_FFFC);
        applyStimulus(0, 1, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        tick();
        checkOutput("wrap pc", PC, 32'h0);
        checkOutput("wrap tmp", PC_Temp, 32'h0);

        // Fetch at 0x20 with three wait states, two PC updates deferred (last wins)
        applyStimulus(0, 1, 1, 0, 32'h0, 32'h20, 0, 32'h0);
        tick();
        applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        tick();
        checkOutput("f2 addr", ROM_Addr, 32'h20);
        applyStimulus(0, 1, 1, 0, 32'h0, 32'h40, 0, 32'h0);
        tick();
        checkOutput("f2 w1 addr", ROM_Addr, 32'h20);
        checkOutput("f2 w1 pc", PC, 32'h20);
        applyStimulus(0, 1, 1, 0, 32'h0, 32'h80, 0, 32'h0);
        tick();
        checkOutput("f2 w2 addr", ROM_Addr, 32'h20);
        checkOutput("f2 w2 pc", PC, 32'h20);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        tick();
        checkOutput("f2 w3 addr", ROM_Addr, 32'h20);
        checkOutput("f2 w3 busy", {31'b0, Fetch_Busy}, 32'h1);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 1, 32'hCAFE_F00D);
        tick();
        checkOutput("f2 ir", Instruction, 32'hCAFE_F00D);
        checkOutput("f2 done", {31'b0, Fetch_Done}, 32'h1);
        checkOutput("f2 pc", PC, 32'h80);
        checkOutput("f2 tmp", PC_Temp, 32'h24);

        // Concurrent fetch + PC update in IDLE, then let it time out
        applyStimulus(1, 1, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        tick();
        checkOutput("f3 addr old pc", ROM_Addr, 32'h80);
        checkOutput("f3 pc", PC, 32'h84);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        for (int i = 0; i < 14; i++) tick();
        checkOutput("f3 still busy", {31'b0, Fetch_Busy}, 32'h1);
        checkOutput("f3 no early err", {31'b0, Fetch_Error}, 32'h0);
        tick();
        checkOutput("f3 error", {31'b0, Fetch_Error}, 32'h1);
        checkOutput("f3 ir nop", Instruction, 32'h0);
        checkOutput("f3 read off", {31'b0, ROM1_Read}, 32'h0);
        checkOutput("f3 busy off", {31'b0, Fetch_Busy}, 32'h0);
        tick();
        checkOutput("f3 error pulse", {31'b0, Fetch_Error}, 32'h0);

        // Reset during the second WAIT cycle
        applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        tick();
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        tick();
        checkOutput("f4 busy", {31'b0, Fetch_Busy}, 32'h1);
        Reset = 1'b1;
        applyStimulus(0, 1, 1, 0, 32'h0, 32'h200, 1, 32'hDEAD_BEEF);
        tick();
        checkResetValues("f4 reset");
        Reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h5555_5555);
        tick();
        checkOutput("idle ready ir", Instruction, 32'h0);
        checkOutput("idle ready done", {31'b0, Fetch_Done}, 32'h0);
        checkOutput("idle ready busy", {31'b0, Fetch_Busy}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
